// File: rtl/hex_keypad_scanner_if.sv
// rtl/hex_keypad_scanner_if.sv - keypad matrix and key/number output bundle for the hex keypad scanner
interface hex_keypad_scanner_if;
   logic [3:0]  row_n;
   logic        clear;
   logic [3:0]  col_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] number;

   // scanner side
   modport slave (
      input  row_n, clear,
      output col_n, key_valid, key_code, key_held, number
   );

   // keypad / consumer side
   modport master (
      output row_n, clear,
      input  col_n, key_valid, key_code, key_held, number
   );
endinterface

// File: rtl/hex_keypad_scanner.sv
// rtl/hex_keypad_scanner.sv - 4x4 hex keypad scanner with debounce, key events and 16-bit digit entry
module hex_keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input logic                 clk,
   input logic                 rst,
   hex_keypad_scanner_if.slave kp
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

   localparam logic [2:0] S_SCAN     = 3'd0;
   localparam logic [2:0] S_DEBOUNCE = 3'd1;
   localparam logic [2:0] S_ACCEPT   = 3'd2;
   localparam logic [2:0] S_HELD     = 3'd3;
   localparam logic [2:0] S_RELEASE  = 3'd4;

   logic [3:0]    sync1_q, sync2_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    col_q, col_d;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cand_row_q, cand_row_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_held_q, key_held_d;
   logic [15:0]   number_q, number_d;

   logic [3:0]    rs;
   logic          tick;
   logic          hit;
   logic [1:0]    hit_row;
   logic [CW-1:0] cnt_inc;
   logic          enter_accept;

   assign rs      = sync2_q;
   assign tick    = (presc_q == PRESC_MAX);
   assign hit     = ~&rs;
   assign cnt_inc = cnt_q + CNT_ONE;

   assign kp.col_n     = ~(4'b0001 << col_q);
   assign kp.key_valid = key_valid_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_held  = key_held_q;
   assign kp.number    = number_q;

   // Two-flop synchronizer for the asynchronous row inputs; idles high like the pull-ups
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
      end else begin
         sync1_q <= kp.row_n;
         sync2_q <= sync1_q;
      end
   end

   // Row priority decode: lowest row index wins when several rows are low
   always_comb begin
      hit_row = 2'd0;
      if (!rs[0])      hit_row = 2'd0;
      else if (!rs[1]) hit_row = 2'd1;
      else if (!rs[2]) hit_row = 2'd2;
      else if (!rs[3]) hit_row = 2'd3;
   end

   // Prescaler, scan/debounce FSM and digit-entry next-state logic
   always_comb begin
      presc_d      = tick ? '0 : presc_q + PRESC_ONE;
      col_d        = col_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      cand_row_d   = cand_row_q;
      key_valid_d  = 1'b0;
      key_code_d   = key_code_q;
      key_held_d   = key_held_q;
      number_d     = kp.clear ? 16'h0000 : number_q;
      enter_accept = 1'b0;

      case (state_q)
         S_SCAN: begin
            if (tick) begin
               if (hit) begin
                  cand_row_d = hit_row;
                  cnt_d      = CNT_ONE;
                  if (DEBOUNCE_SCANS == 1) enter_accept = 1'b1;
                  else                     state_d      = S_DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         S_DEBOUNCE: begin
            if (tick) begin
               if (hit && (hit_row == cand_row_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) enter_accept = 1'b1;
               end else begin
                  cnt_d   = '0;
                  state_d = S_SCAN;
                  col_d   = col_q + 2'd1;
               end
            end
         end
         S_ACCEPT: begin
            // A coincident clear wipes the old digits but keeps the new one
            number_d = kp.clear ? {12'h000, key_code_q} : {number_q[11:0], key_code_q};
            state_d  = S_HELD;
         end
         S_HELD: begin
            if (tick && !hit) begin
               cnt_d = CNT_ONE;
               if (DEBOUNCE_SCANS == 1) begin
                  cnt_d      = '0;
                  key_held_d = 1'b0;
                  state_d    = S_SCAN;
                  col_d      = col_q + 2'd1;
               end else begin
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            if (tick) begin
               if (!hit) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     cnt_d      = '0;
                     key_held_d = 1'b0;
                     state_d    = S_SCAN;
                     col_d      = col_q + 2'd1;
                  end
               end else begin
                  state_d = S_HELD;
               end
            end
         end
         default: state_d = S_SCAN;
      endcase

      // Column stays frozen while a key is in flight, so the candidate column is col_q
      if (enter_accept) begin
         state_d     = S_ACCEPT;
         key_valid_d = 1'b1;
         key_code_d  = {cand_row_d, col_q};
         key_held_d  = 1'b1;
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         col_q       <= 2'd0;
         state_q     <= S_SCAN;
         cnt_q       <= '0;
         cand_row_q  <= 2'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
         number_q    <= 16'h0000;
      end else begin
         presc_q     <= presc_d;
         col_q       <= col_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_row_q  <= cand_row_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
         number_q    <= number_d;
      end
   end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb/tb_hex_keypad_scanner.sv - directed self-checking bench for hex_keypad_scanner
module tb_hex_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_tb = 1'b0;
   logic [15:0] pressed = 16'h0000;
   logic [3:0]  row_force_n = 4'hF;
   logic [3:0]  kp_rows_n;
   int          tests = 0;
   int          fails = 0;

   hex_keypad_scanner_if ifc ();

   hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (ifc)
   );

   always #5 clk = ~clk;

   // Keypad matrix model: a pressed key pulls its row low while its column is driven low
   always_comb begin
      kp_rows_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !ifc.col_n[c]) kp_rows_n[r] = 1'b0;
   end

   assign ifc.row_n = kp_rows_n & row_force_n;
   assign ifc.clear = clear_tb;

   task automatic wait_valid(input int budget, output bit ok, output logic [3:0] code);
      ok = 1'b0;
      code = 4'h0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (ifc.key_valid === 1'b1) begin
            ok = 1'b1;
            code = ifc.key_code;
         end
      end
   endtask

   task automatic wait_release(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (ifc.key_held === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic press_key(input logic [3:0] code, input bit clr, output bit okv,
                            output logic [3:0] got, output bit okr);
      pressed = 16'h0001 << code;
      wait_valid(200, okv, got);
      if (okv && clr) begin
         clear_tb = 1'b1;
         @(negedge clk);
         clear_tb = 1'b0;
      end
      pressed = 16'h0000;
      wait_release(200, okr);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (ifc.col_n !== 4'b1110) begin fails++; $display("FAIL reset_col_n: got %b expected 1110", ifc.col_n); end
      tests++; if (ifc.key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %b expected 0", ifc.key_valid); end
      tests++; if (ifc.key_code !== 4'h0) begin fails++; $display("FAIL reset_key_code: got %h expected 0", ifc.key_code); end
      tests++; if (ifc.key_held !== 1'b0) begin fails++; $display("FAIL reset_key_held: got %b expected 0", ifc.key_held); end
      tests++; if (ifc.number !== 16'h0000) begin fails++; $display("FAIL reset_number: got %h expected 0000", ifc.number); end
   endtask

   task automatic test_idle();
      logic [3:0] exp_col;
      int pulses;
      pulses = 0;
      rst = 1'b0;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((n / 4) % 4));
         if (ifc.key_valid === 1'b1) pulses++;
         tests++; if (ifc.col_n !== exp_col) begin fails++; $display("FAIL idle_col_n[%0d]: got %b expected %b", n, ifc.col_n, exp_col); end
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL idle_key_valid: got %0d pulses expected 0", pulses); end
      tests++; if (ifc.number !== 16'h0000) begin fails++; $display("FAIL idle_number: got %h expected 0000", ifc.number); end
   endtask

   task automatic test_clean_press();
      bit found;
      int pulses;
      found = 1'b0;
      pulses = 0;
      pressed = 16'h0001 << 9;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (ifc.col_n === 4'b1101) found = 1'b1;
      end
      tests++; if (!found) begin fails++; $display("FAIL clean_col1_timeout: got col_n %b expected 1101", ifc.col_n); end
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (ifc.key_valid === 1'b1) pulses++;
         if (k == 8) begin
            tests++; if (ifc.key_valid !== 1'b1) begin fails++; $display("FAIL clean_latency: got key_valid %b expected 1", ifc.key_valid); end
            tests++; if (ifc.key_code !== 4'h9) begin fails++; $display("FAIL clean_key_code: got %h expected 9", ifc.key_code); end
         end
         if (k == 9) begin
            tests++; if (ifc.number !== 16'h0009) begin fails++; $display("FAIL clean_number: got %h expected 0009", ifc.number); end
         end
         if (k == 40) pressed = 16'h0000;
         if (k == 47) begin
            tests++; if (ifc.key_held !== 1'b1) begin fails++; $display("FAIL clean_held_before_release: got %b expected 1", ifc.key_held); end
         end
         if (k == 48) begin
            tests++; if (ifc.key_held !== 1'b0) begin fails++; $display("FAIL clean_held_after_release: got %b expected 0", ifc.key_held); end
            tests++; if (ifc.col_n !== 4'b1011) begin fails++; $display("FAIL clean_col_advance: got %b expected 1011", ifc.col_n); end
         end
      end
      tests++; if (pulses !== 1) begin fails++; $display("FAIL clean_pulse_count: got %0d expected 1", pulses); end
   endtask

   task automatic test_bounce();
      bit found;
      int pulses;
      found = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (ifc.col_n === 4'b0111) found = 1'b1;
      end
      tests++; if (!found) begin fails++; $display("FAIL bounce_col3_timeout: got col_n %b expected 0111", ifc.col_n); end
      row_force_n = 4'b1110;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (ifc.key_valid === 1'b1) pulses++;
         if (k == 4) row_force_n = 4'b1111;
         if (k == 7) begin
            tests++; if (ifc.col_n !== 4'b0111) begin fails++; $display("FAIL bounce_col_frozen: got %b expected 0111", ifc.col_n); end
         end
         if (k == 8) begin
            tests++; if (ifc.col_n !== 4'b1110) begin fails++; $display("FAIL bounce_col_advance: got %b expected 1110", ifc.col_n); end
         end
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL bounce_key_valid: got %0d pulses expected 0", pulses); end
      tests++; if (ifc.key_held !== 1'b0) begin fails++; $display("FAIL bounce_key_held: got %b expected 0", ifc.key_held); end
   endtask

   task automatic test_digit_entry();
      logic [3:0]  codes [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      logic [15:0] exp_num [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2345};
      bit okv, okr;
      logic [3:0] got;
      clear_tb = 1'b1;
      @(negedge clk);
      clear_tb = 1'b0;
      tests++; if (ifc.number !== 16'h0000) begin fails++; $display("FAIL digit_clear: got %h expected 0000", ifc.number); end
      for (int i = 0; i < 5; i++) begin
         press_key(codes[i], 1'b0, okv, got, okr);
         tests++; if (okv !== 1'b1) begin fails++; $display("FAIL digit_valid_timeout[%0d]: got %b expected 1", i, okv); end
         tests++; if (got !== codes[i]) begin fails++; $display("FAIL digit_code[%0d]: got %h expected %h", i, got, codes[i]); end
         tests++; if (ifc.number !== exp_num[i]) begin fails++; $display("FAIL digit_number[%0d]: got %h expected %h", i, ifc.number, exp_num[i]); end
         tests++; if (okr !== 1'b1) begin fails++; $display("FAIL digit_release_timeout[%0d]: got %b expected 1", i, okr); end
      end
   endtask

   task automatic test_priority();
      bit okv, okr;
      logic [3:0] got;
      int pulses;
      pulses = 0;
      pressed = (16'h0001 << 4) | (16'h0001 << 12);
      wait_valid(200, okv, got);
      tests++; if (okv !== 1'b1) begin fails++; $display("FAIL prio_valid_timeout: got %b expected 1", okv); end
      tests++; if (got !== 4'h4) begin fails++; $display("FAIL prio_code: got %h expected 4", got); end
      pressed = pressed | (16'h0001 << 8);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ifc.key_valid === 1'b1) pulses++;
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL prio_second_key_event: got %0d pulses expected 0", pulses); end
      tests++; if (ifc.key_held !== 1'b1) begin fails++; $display("FAIL prio_held: got %b expected 1", ifc.key_held); end
      tests++; if (ifc.key_code !== 4'h4) begin fails++; $display("FAIL prio_code_kept: got %h expected 4", ifc.key_code); end
      tests++; if (ifc.number !== 16'h3454) begin fails++; $display("FAIL prio_number: got %h expected 3454", ifc.number); end
      pressed = 16'h0000;
      wait_release(200, okr);
      tests++; if (okr !== 1'b1) begin fails++; $display("FAIL prio_release_timeout: got %b expected 1", okr); end
   endtask

   task automatic test_clear_reset();
      bit okv, okr;
      logic [3:0] got;
      clear_tb = 1'b1;
      @(negedge clk);
      clear_tb = 1'b0;
      tests++; if (ifc.number !== 16'h0000) begin fails++; $display("FAIL cr_clear: got %h expected 0000", ifc.number); end
      for (int i = 1; i <= 4; i++) press_key(4'(i), 1'b0, okv, got, okr);
      tests++; if (ifc.number !== 16'h1234) begin fails++; $display("FAIL cr_number_1234: got %h expected 1234", ifc.number); end
      press_key(4'hF, 1'b1, okv, got, okr);
      tests++; if (okv !== 1'b1) begin fails++; $display("FAIL cr_f_valid_timeout: got %b expected 1", okv); end
      tests++; if (got !== 4'hF) begin fails++; $display("FAIL cr_f_code: got %h expected f", got); end
      tests++; if (ifc.number !== 16'h000F) begin fails++; $display("FAIL cr_clear_on_accept: got %h expected 000f", ifc.number); end
      pressed = 16'h0001 << 6;
      wait_valid(200, okv, got);
      repeat (3) @(negedge clk);
      tests++; if (ifc.key_held !== 1'b1) begin fails++; $display("FAIL cr_held_before_rst: got %b expected 1", ifc.key_held); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (ifc.col_n !== 4'b1110) begin fails++; $display("FAIL cr_rst_col_n: got %b expected 1110", ifc.col_n); end
      tests++; if (ifc.key_valid !== 1'b0) begin fails++; $display("FAIL cr_rst_key_valid: got %b expected 0", ifc.key_valid); end
      tests++; if (ifc.key_code !== 4'h0) begin fails++; $display("FAIL cr_rst_key_code: got %h expected 0", ifc.key_code); end
      tests++; if (ifc.key_held !== 1'b0) begin fails++; $display("FAIL cr_rst_key_held: got %b expected 0", ifc.key_held); end
      tests++; if (ifc.number !== 16'h0000) begin fails++; $display("FAIL cr_rst_number: got %h expected 0000", ifc.number); end
      rst = 1'b0;
      wait_valid(200, okv, got);
      tests++; if (okv !== 1'b1) begin fails++; $display("FAIL cr_redetect_timeout: got %b expected 1", okv); end
      tests++; if (got !== 4'h6) begin fails++; $display("FAIL cr_redetect_code: got %h expected 6", got); end
      pressed = 16'h0000;
      wait_release(200, okr);
      tests++; if (okr !== 1'b1) begin fails++; $display("FAIL cr_release_timeout: got %b expected 1", okr); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_clean_press();
      test_bounce();
      test_digit_entry();
      test_priority();
      test_clear_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Input-side counterpart to the multiplexed 7-segment hex display driver. Scans a 4x4 matrix hex keypad by driving one active-low column at a time and reading four active-low rows. Debounces presses and emits a one-cycle key event with a 4-bit code. Shifts each accepted hex digit into a 16-bit entry register, which feeds the display driver's number input.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick; prescaler counts 0..SCAN_DIV-1; minimum 2
DEBOUNCE_SCANS, 4, consecutive identical tick samples required to accept a press or a release; minimum 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
row_n  input  4  keypad rows, active-low (external pull-ups), asynchronous
clear  input  1  synchronous clear of number
col_n  output  4  column drive, active-low, exactly one bit low at all times
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  code of last accepted key, = 4*row_index + col_index
key_held  output  1  high from acceptance until debounced release
number  output  16  entered value; newest digit in [3:0]

Behaviour:
- row_n passes through a 2-FF synchronizer; all logic uses the synchronized value rs.
- Prescaler: increments every cycle, wraps to 0 at SCAN_DIV-1; "tick" is the cycle where it equals SCAN_DIV-1.
- Sampling occurs only on tick. Column changes take effect on the same tick edge, so each column is stable for a full period before it is next sampled.
- Row decode: any rs bit low = hit. With several low rows, the lowest index wins (row 0 highest priority).
- FSM states: SCAN, DEBOUNCE, ACCEPT, HELD, RELEASE.
- SCAN, tick, no hit: rotate the active column 0->1->2->3->0.
- SCAN, tick, hit: latch cand_row/cand_col, set cnt=1, hold the column. If DEBOUNCE_SCANS=1, go to ACCEPT; otherwise go to DEBOUNCE.
- DEBOUNCE, tick, same row hit: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to ACCEPT.
- DEBOUNCE, tick, different or no hit: return to SCAN and advance the column. No event is produced.
- ACCEPT (exactly one cycle):
  - key_valid=1; key_code={cand_row,cand_col}; key_held=1.
  - number <= {number[11:0], code}.
  - Go to HELD.
- HELD, tick, all rs high: cnt=1, go to RELEASE (or to SCAN if DEBOUNCE_SCANS=1).
- RELEASE, tick, all rs high: cnt+1. When cnt reaches DEBOUNCE_SCANS: key_held=0, go to SCAN, advance the column.
- RELEASE, tick, any hit: back to HELD. No new event; auto-repeat is not supported.
- The column is frozen throughout DEBOUNCE/ACCEPT/HELD/RELEASE. Second keys pressed while a key is held are ignored.
- clear: number<=0 in any state. If clear coincides with ACCEPT, the result is number={12'h000, code}.
- Digit shift: number[15:12] is discarded on every accept (wrap-around by shift).
- Reset values:
  - col_n=4'b1110.
  - key_valid=0, key_code=0, key_held=0, number=16'h0000.
  - Prescaler=0, cnt=0, state=SCAN.
  - Synchronizer flops=4'b1111.
- Reset mid-press: returns to SCAN at column 0. A still-held key is re-detected and accepted again after debounce; this is intended.
- key_valid latency: 1 clk after the tick that completes the DEBOUNCE_SCANS-th matching sample.
- key_code and number hold their values until the next accept, clear, or reset.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2 unless stated.)
- Idle: rows all high for 64 cycles -> col_n cycles 1110,1101,1011,0111 and changes every 4 clks; key_valid never asserts; number=0000.
- Clean press: row 2 low while col 1 is active, held for 40 clks -> exactly one key_valid pulse with key_code=9, 1 clk after the 2nd matching tick. number=0009, key_held=1 until 2 release ticks after the row goes high.
- Bounce rejection: row 0 low for exactly one tick sample on col 3, then high -> no key_valid; FSM returns to SCAN; column advances to 0.
- Digit entry: press codes 1,2,3,4,5 sequentially with full releases -> number shows 0001, 0012, 0123, 1234, 2345 after each key_valid.
- Multi-row priority and frozen column: rows 1 and 3 low on col 0 -> key_code=4. A subsequent row 2 press on col 0, made while row 1 is still held, yields no new event.
- Clear and reset: clear asserted in the same cycle as ACCEPT for code 0xF with number=1234 -> number=000F. Asserting rst during HELD -> all outputs at reset values the next cycle; col_n=1110.
